// File: rtl/debounce_multi.sv
// Multi-channel button debouncer with press, release,
// long-press and auto-repeat event pulses.
module debounce_multi #(
   parameter int N_CH          = 4,
   parameter int CNT_W         = 16,
   parameter int DB_CYCLES     = 65530,
   parameter int HOLD_CYCLES   = 50000,
   parameter int REPEAT_CYCLES = 10000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   input  logic            repeat_en,
   output logic [N_CH-1:0] btn_state,
   output logic [N_CH-1:0] btn_pressed,
   output logic [N_CH-1:0] btn_released,
   output logic [N_CH-1:0] btn_long,
   output logic [N_CH-1:0] btn_repeat
);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } hs_t;

   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_T   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES);

   logic [N_CH-1:0]  s1, s2;
   logic [N_CH-1:0]  state_d, press_d, rel_d, long_d, rpt_d;
   logic [CNT_W-1:0] db_q   [N_CH];
   logic [CNT_W-1:0] db_d   [N_CH];
   logic [CNT_W-1:0] hold_q [N_CH];
   logic [CNT_W-1:0] hold_d [N_CH];
   logic [CNT_W-1:0] rep_q  [N_CH];
   logic [CNT_W-1:0] rep_d  [N_CH];
   hs_t              hs_q   [N_CH];
   hs_t              hs_d   [N_CH];

   always_comb begin
      state_d = btn_state;
      press_d = '0;
      rel_d   = '0;
      long_d  = '0;
      rpt_d   = '0;
      for (int i = 0; i < N_CH; i++) begin
         db_d[i]   = db_q[i];
         hold_d[i] = hold_q[i];
         rep_d[i]  = rep_q[i];
         hs_d[i]   = hs_q[i];

         if (s2[i] == btn_state[i]) begin
            db_d[i] = '0;
         end else if (db_q[i] == DB_T) begin
            db_d[i]    = '0;
            state_d[i] = s2[i];
            press_d[i] = s2[i];
            rel_d[i]   = ~s2[i];
         end else begin
            db_d[i] = db_q[i] + ONE;
         end

         // Release overrides any long/repeat due on the same edge
         if (rel_d[i]) begin
            hs_d[i]   = IDLE;
            hold_d[i] = '0;
            rep_d[i]  = '0;
         end else begin
            unique case (hs_q[i])
               IDLE: begin
                  if (press_d[i]) begin
                     hs_d[i]   = HOLD;
                     hold_d[i] = ONE;
                  end
               end
               HOLD: begin
                  if (hold_q[i] == HOLD_T) begin
                     long_d[i] = 1'b1;
                     hs_d[i]   = REPEAT;
                     hold_d[i] = '0;
                     rep_d[i]  = ONE;
                  end else begin
                     hold_d[i] = hold_q[i] + ONE;
                  end
               end
               REPEAT: begin
                  if (rep_q[i] == REP_T) begin
                     rpt_d[i] = repeat_en;
                     rep_d[i] = ONE;
                  end else begin
                     rep_d[i] = rep_q[i] + ONE;
                  end
               end
               default: begin
                  hs_d[i]   = IDLE;
                  hold_d[i] = '0;
                  rep_d[i]  = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1           <= '0;
         s2           <= '0;
         btn_state    <= '0;
         btn_pressed  <= '0;
         btn_released <= '0;
         btn_long     <= '0;
         btn_repeat   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            db_q[i]   <= '0;
            hold_q[i] <= '0;
            rep_q[i]  <= '0;
            hs_q[i]   <= IDLE;
         end
      end else begin
         s1           <= btn_in;
         s2           <= s1;
         btn_state    <= state_d;
         btn_pressed  <= press_d;
         btn_released <= rel_d;
         btn_long     <= long_d;
         btn_repeat   <= rpt_d;
         for (int i = 0; i < N_CH; i++) begin
            db_q[i]   <= db_d[i];
            hold_q[i] <= hold_d[i];
            rep_q[i]  <= rep_d[i];
            hs_q[i]   <= hs_d[i];
         end
      end
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with N_CH=2, DB=8,
// HOLD=20, REPEAT=5.
module tb_debounce_multi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] btn_in = 2'b00;
   logic       repeat_en = 1'b1;
   logic [1:0] btn_state, btn_pressed, btn_released;
   logic [1:0] btn_long, btn_repeat;

   int checks = 0;
   int errors = 0;
   int n_pr[2] = '{0, 0};
   int n_rl[2] = '{0, 0};
   int n_lg[2] = '{0, 0};
   int n_rp[2] = '{0, 0};

   always #5 clk = ~clk;

   debounce_multi #(
      .N_CH(2), .CNT_W(16), .DB_CYCLES(8),
      .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
      .repeat_en(repeat_en), .btn_state(btn_state),
      .btn_pressed(btn_pressed), .btn_released(btn_released),
      .btn_long(btn_long), .btn_repeat(btn_repeat)
   );

   // Pulse tallies catch events that land between checked edges
   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (btn_pressed[c])  n_pr[c] = n_pr[c] + 1;
         if (btn_released[c]) n_rl[c] = n_rl[c] + 1;
         if (btn_long[c])     n_lg[c] = n_lg[c] + 1;
         if (btn_repeat[c])   n_rp[c] = n_rp[c] + 1;
      end
   end

   typedef struct {
      int         n;
      logic [1:0] btn;
      logic       ren;
      logic [1:0] st, pr, rl, lg, rp;
      string      tag;
   } vec_t;

   vec_t tbl[$];

   task automatic cmp(string nm, logic [1:0] act, logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic cmpi(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(string t, logic [1:0] st, logic [1:0] pr,
                      logic [1:0] rl, logic [1:0] lg, logic [1:0] rp);
      cmp({t, ".state"}, btn_state, st);
      cmp({t, ".pressed"}, btn_pressed, pr);
      cmp({t, ".released"}, btn_released, rl);
      cmp({t, ".long"}, btn_long, lg);
      cmp({t, ".repeat"}, btn_repeat, rp);
   endtask

   function automatic vec_t mk(int n, logic [1:0] b, logic r,
                               logic [1:0] st, logic [1:0] pr,
                               logic [1:0] rl, logic [1:0] lg,
                               logic [1:0] rp, string t);
      vec_t v;
      v.n = n; v.btn = b; v.ren = r;
      v.st = st; v.pr = pr; v.rl = rl; v.lg = lg; v.rp = rp;
      v.tag = t;
      return v;
   endfunction

   int b_pr0;

   initial begin
      // clean press/release on ch0
      tbl.push_back(mk(3, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "idle"));
      tbl.push_back(mk(9, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "c.pre"));
      tbl.push_back(mk(1, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, "c.press"));
      tbl.push_back(mk(1, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "c.after"));
      tbl.push_back(mk(10, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, "c.rel"));
      tbl.push_back(mk(1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "c.quiet"));
      // long press and repeat on ch1
      tbl.push_back(mk(10, 2'b10, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, "l.press"));
      tbl.push_back(mk(19, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "l.p19"));
      tbl.push_back(mk(1, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, "l.long"));
      tbl.push_back(mk(5, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, "l.rep25"));
      tbl.push_back(mk(2, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "l.p27"));
      tbl.push_back(mk(3, 2'b10, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "l.gated30"));
      tbl.push_back(mk(5, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, "l.rep35"));
      tbl.push_back(mk(5, 2'b00, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, "l.rep40"));
      tbl.push_back(mk(5, 2'b00, 1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, "l.rel45"));
      tbl.push_back(mk(10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "l.quiet"));
      // short hold on ch0
      tbl.push_back(mk(10, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, "s.press"));
      tbl.push_back(mk(5, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "s.p5"));
      tbl.push_back(mk(10, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, "s.rel15"));
      tbl.push_back(mk(10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "s.quiet"));
      // both channels at once
      tbl.push_back(mk(10, 2'b11, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, "b.press"));
      tbl.push_back(mk(10, 2'b00, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "b.rel"));
      tbl.push_back(mk(3, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "b.quiet"));

      step(3);
      chk("reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         btn_in    = tbl[k].btn;
         repeat_en = tbl[k].ren;
         step(tbl[k].n);
         chk(tbl[k].tag, tbl[k].st, tbl[k].pr, tbl[k].rl,
             tbl[k].lg, tbl[k].rp);
      end

      cmpi("cnt.pr0", n_pr[0], 3);
      cmpi("cnt.pr1", n_pr[1], 2);
      cmpi("cnt.rl0", n_rl[0], 3);
      cmpi("cnt.rl1", n_rl[1], 2);
      cmpi("cnt.lg0", n_lg[0], 0);
      cmpi("cnt.lg1", n_lg[1], 1);
      cmpi("cnt.rp0", n_rp[0], 0);
      cmpi("cnt.rp1", n_rp[1], 3);

      // bounce: 13 toggles of 3 cycles each, ending high
      b_pr0 = n_pr[0];
      for (int k = 0; k < 13; k++) begin
         btn_in[0] = ~btn_in[0];
         step(3);
      end
      step(6);
      chk("bn.hold9", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      cmpi("bn.nopress", n_pr[0] - b_pr0, 0);
      step(1);
      chk("bn.press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);

      // reset in the middle of a hold
      step(12);
      rst_n = 1'b0;
      #1;
      chk("r.async", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      step(2);
      chk("r.held", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      rst_n = 1'b1;
      b_pr0 = n_pr[0];
      step(9);
      chk("r.pre", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      step(1);
      chk("r.press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
      step(19);
      chk("r.p19", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      step(1);
      chk("r.long", 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
      cmpi("r.onepress", n_pr[0] - b_pr0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
